// File: rtl/toggle_counter_pkg.sv
// Shared constants and the per-bit toggle function for the T flip-flop counter chain.
package toggle_counter_pkg;

  localparam logic DIR_UP        = 1'b1;
  localparam logic DIR_DOWN      = 1'b0;
  localparam int   DEFAULT_WIDTH = 4;
  localparam int   MAX_WIDTH     = 32;

  // Bit i toggles when every lower bit is 1 (up) or every lower bit is 0 (down).
  function automatic logic [MAX_WIDTH-1:0] toggle_vector(input logic [MAX_WIDTH-1:0] q,
                                                         input logic                 up);
    logic [MAX_WIDTH-1:0] t;
    logic                 run;
    run = 1'b1;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      t[i] = run;
      run  = run & ((up == DIR_DOWN) ? ~q[i] : q[i]);
    end
    return t;
  endfunction

endpackage

// File: rtl/t_ff.sv
// One-bit T flip-flop with synchronous reset and parallel load (rst > Ld > En&T).
module t_ff (
  input  logic clk,
  input  logic rst,
  input  logic En,
  input  logic T,
  input  logic Ld,
  input  logic D,
  output logic Q
);

  logic q_d;
  logic q_q;

  // Next-state selection: load overrides toggle
  always_comb begin
    q_d = q_q;
    if (Ld) begin
      q_d = D;
    end else if (En && T) begin
      q_d = ~q_q;
    end else begin
      q_d = q_q;
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q = q_q;

endmodule

// File: rtl/toggle_counter.sv
// Up/down counter built from a chain of t_ff cells, with load, terminal count and sticky overflow.
// Define TOGGLE_COUNTER_MOD_EN to make the counter modulo MOD_VALUE.
module toggle_counter
  import toggle_counter_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int MOD_VALUE = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             En,
  input  logic             Up,
  input  logic             Load,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_bar,
  output logic             TC,
  output logic             OVF
);

`ifdef TOGGLE_COUNTER_MOD_EN
  localparam bit MOD_EN = 1'b1;
  localparam logic [WIDTH:0] MOD_LIMIT = (WIDTH+1)'(MOD_VALUE);
`else
  localparam bit MOD_EN = 1'b0;
`endif
  localparam logic [WIDTH-1:0] TOP = MOD_EN ? WIDTH'(MOD_VALUE - 1) : {WIDTH{1'b1}};

  logic [WIDTH-1:0] q_s;
  logic [WIDTH-1:0] full_t_s;
  logic [WIDTH-1:0] t_s;
  logic [WIDTH-1:0] d_load_s;
  logic             wrap_s;
  logic             ovf_d;
  logic             ovf_q;

  // Toggle vector and load value; modulo mode forces the wrap value through the same cells
  always_comb begin
    full_t_s = WIDTH'(toggle_vector(MAX_WIDTH'(q_s), Up));
    wrap_s   = (Up == DIR_UP) ? (q_s == TOP) : (q_s == {WIDTH{1'b0}});
`ifdef TOGGLE_COUNTER_MOD_EN
    if (wrap_s) begin
      t_s = q_s ^ ((Up == DIR_UP) ? {WIDTH{1'b0}} : TOP);
    end else begin
      t_s = full_t_s;
    end
    d_load_s = ({1'b0, D} >= MOD_LIMIT) ? TOP : D;
`else
    t_s      = full_t_s;
    d_load_s = D;
`endif
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    t_ff u_t_ff (
      .clk (clk),
      .rst (rst),
      .En  (En),
      .T   (t_s[i]),
      .Ld  (Load),
      .D   (d_load_s[i]),
      .Q   (q_s[i])
    );
  end

  // Sticky overflow: set by an enabled wrap, cleared by load
  always_comb begin
    ovf_d = ovf_q;
    if (Load) begin
      ovf_d = 1'b0;
    end else if (En && wrap_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Overflow register
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign Q     = q_s;
  assign Q_bar = ~q_s;
  assign TC    = En & ~Load & wrap_s;
  assign OVF   = ovf_q;

endmodule

// File: tb/tb_toggle_counter.sv
// Scoreboard bench for toggle_counter: directed scenarios plus random traffic against an arithmetic model.
module tb_toggle_counter;

  localparam int W    = 4;
  localparam int MODV = 10;
`ifdef TOGGLE_COUNTER_MOD_EN
  localparam int TOPV = MODV - 1;
  localparam bit MODE = 1'b1;
`else
  localparam int TOPV = (1 << W) - 1;
  localparam bit MODE = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0;
  logic         up = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] d = '0;
  logic [W-1:0] q;
  logic [W-1:0] q_bar;
  logic         tc;
  logic         ovf;

  always #5 clk = ~clk;

  toggle_counter #(.WIDTH(W), .MOD_VALUE(MODV)) dut (
    .clk   (clk),
    .rst   (rst),
    .En    (en),
    .Up    (up),
    .Load  (load),
    .D     (d),
    .Q     (q),
    .Q_bar (q_bar),
    .TC    (tc),
    .OVF   (ovf)
  );

  typedef struct { bit chk; logic [W-1:0] q; bit ovf; int id; } st_exp_t;
  typedef struct { bit chk; bit tc; int id; } tc_exp_t;

  st_exp_t st_q[$];
  tc_exp_t tc_q[$];
  int      checks   = 0;
  int      failures = 0;
  int      m_q      = 0;
  bit      m_ovf    = 1'b0;
  bit      m_valid  = 1'b0;
  int      step_id  = 0;

  task automatic step(input bit r, input bit e, input bit u, input bit l, input int dv);
    tc_exp_t te;
    st_exp_t se;
    @(posedge clk);
    #2;
    rst = r; en = e; up = u; load = l; d = dv[W-1:0];
    te.chk = m_valid;
    te.tc  = e && !l && (u ? (m_q == TOPV) : (m_q == 0));
    te.id  = step_id;
    tc_q.push_back(te);
    if (r) begin
      m_q = 0; m_ovf = 1'b0; m_valid = 1'b1;
    end else if (l) begin
      m_q   = (MODE && dv >= MODV) ? MODV - 1 : dv;
      m_ovf = 1'b0;
    end else if (e) begin
      if (u) begin
        if (m_q == TOPV) begin m_q = 0; m_ovf = 1'b1; end
        else m_q = m_q + 1;
      end else begin
        if (m_q == 0) begin m_q = TOPV; m_ovf = 1'b1; end
        else m_q = m_q - 1;
      end
    end
    se.chk = m_valid;
    se.q   = m_q[W-1:0];
    se.ovf = m_ovf;
    se.id  = step_id;
    st_q.push_back(se);
    step_id++;
  endtask

  // TC monitor: inputs are stable mid-cycle
  initial begin
    tc_exp_t te;
    forever begin
      @(negedge clk);
      if (tc_q.size() > 0) begin
        te = tc_q.pop_front();
        if (te.chk) begin
          checks++;
          if (tc !== te.tc) begin
            failures++;
            $display("FAIL tc step=%0d actual=%b required=%b", te.id, tc, te.tc);
          end
        end
      end
    end
  end

  // State monitor: sample just after the edge that applied the step
  initial begin
    st_exp_t se;
    forever begin
      @(posedge clk);
      #1;
      if (st_q.size() > 0) begin
        se = st_q.pop_front();
        if (se.chk) begin
          checks += 3;
          if (q !== se.q) begin
            failures++;
            $display("FAIL q step=%0d actual=%b required=%b", se.id, q, se.q);
          end
          if (q_bar !== ~se.q) begin
            failures++;
            $display("FAIL q_bar step=%0d actual=%b required=%b", se.id, q_bar, ~se.q);
          end
          if (ovf !== se.ovf) begin
            failures++;
            $display("FAIL ovf step=%0d actual=%b required=%b", se.id, ovf, se.ovf);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // reset with En and Load high
    step(1, 1, 1, 1, 5); step(1, 1, 1, 1, 5);
    step(0, 1, 0, 0, 0);                         // TC=1 at Q=0 counting down, wraps
    step(1, 0, 0, 0, 0);
    // up wrap
    step(0, 0, 1, 1, 13);
    repeat (3) step(0, 1, 1, 0, 0);
    // down wrap then hold
    step(0, 0, 0, 1, 1);
    repeat (2) step(0, 1, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0);
    // load priority over count
    step(0, 0, 1, 1, 6);
    step(0, 1, 1, 1, 3);
    step(0, 1, 1, 0, 0);
    // modulo-relevant boundaries
    step(0, 0, 1, 1, 8);
    repeat (2) step(0, 1, 1, 0, 0);
    step(0, 0, 1, 1, 12);
    step(0, 0, 1, 1, 15);
    step(0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0);
    // reset mid-count
    step(0, 0, 1, 1, 7);
    step(1, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
           ($urandom_range(0, 7) == 0), $urandom_range(0, (1 << W) - 1));
    end
    step(0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #3;
    checks++;
    if (st_q.size() != 0 || tc_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d/%0d required=0/0", st_q.size(), tc_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/toggle_counter.md
# toggle_counter

Synchronous N-bit up/down counter built from a chain of T flip-flop cells. It follows the T latch stage in the latches/flip-flops series and turns the toggle storage element into a usable register. Each bit's toggle input is derived from the lower bits and the count direction. The counter provides parallel load, a terminal-count indication and a sticky overflow flag, and serves as the standard event/divider counter for later practice designs.

## Interface
Parameters:
- WIDTH, 4, counter width in bits (≥2)
- MOD_VALUE, 10, modulus; used only when TOGGLE_COUNTER_MOD_EN is defined; must satisfy 2 ≤ MOD_VALUE ≤ 2^WIDTH

Ports:
- clk  input  1  rising-edge clock; the only clock
- rst  input  1  reset, synchronous, active-high
- En  input  1  count enable; when low, Q holds
- Up  input  1  direction: 1 counts up, 0 counts down
- Load  input  1  parallel load strobe
- D  input  WIDTH  load value
- Q  output  WIDTH  counter value (registered)
- Q_bar  output  WIDTH  bitwise ~Q
- TC  output  1  terminal count, combinational: En & ~Load & (Up ? Q==TOP : Q==0)
- OVF  output  1  sticky wrap flag (registered)

TOP is 2^WIDTH−1, or MOD_VALUE−1 when TOGGLE_COUNTER_MOD_EN is defined.

## Operation
Action priority on each rising clk edge: rst > Load > En > hold.
- rst: Q=0, OVF=0.
- Load: Q=D (clamped, see Configuration); OVF=0; En ignored.
- En, up: Q=Q+1; at Q==TOP, Q becomes 0 and OVF is set.
- En, down: Q=Q−1; at Q==0, Q becomes TOP and OVF is set.
- En low, no Load: Q and OVF hold.

Toggle generation in full-range mode:
- T[0]=1.
- T[i]=&Q[i-1:0] when counting up.
- T[i]=&~Q[i-1:0] when counting down.
- Cell i toggles when its enable and T[i] are both high.

Modulo mode: at the wrap point, T = Q ^ next_value, so the same cells are used.

Other rules:
- Direction changes take effect on the next enabled edge. There is no pipeline state.
- OVF is cleared only by rst or Load. A wrap coinciding with Load does not set OVF.
- Q_bar is always ~Q and never X after the first reset edge.

## Timing
- Reset values: Q=0, Q_bar=all ones, OVF=0, TC=0 when En=0. TC=1 after reset if En=1 and Up=0, because Q==0.
- Latency: one cycle from En/Load/rst sampled high to Q updated.
- TC is valid in the same cycle as Q. It flags that the next enabled edge wraps.
- OVF rises on the edge that performs the wrap, coincident with Q wrapping.
- Reset mid-count: Q=0 on that edge, regardless of En, Load or Up.
- Load together with En: Load wins, Q=D, and no count occurs in that cycle.

## Configuration
- TOGGLE_COUNTER_MOD_EN defined:
  - The counter is modulo MOD_VALUE.
  - Up-counting wraps from MOD_VALUE−1 to 0.
  - Down-counting wraps from 0 to MOD_VALUE−1.
  - A Load value D ≥ MOD_VALUE loads MOD_VALUE−1.
  - TOP = MOD_VALUE−1.
- Undefined:
  - Full binary range 0..2^WIDTH−1.
  - MOD_VALUE is ignored.
  - D is loaded unmodified.

## Structure
- Package toggle_counter_pkg:
  - DIR_UP=1'b1 and DIR_DOWN=1'b0 constants.
  - Default WIDTH.
  - Function computing the per-bit toggle vector from (Q, Up).
- Sub-module t_ff: one-bit T flip-flop.
  - Ports: clk, rst, En, T, Ld, D, Q.
  - Synchronous active-high reset.
  - Priority: rst > Ld > (En & T toggles).
  - Instantiated WIDTH times with a generate loop.
- Top level contains the toggle-vector logic, the modulo wrap override, TC and OVF.

## Test plan
All scenarios use WIDTH=4.
- Reset: rst=1 for 2 cycles with En=1 and Load=1 → Q=0000, Q_bar=1111, OVF=0.
- Up wrap, macro off: Load D=1101, then En=1, Up=1 for 3 cycles → Q=1110, 1111, 0000. TC=1 while Q=1111. OVF=1 from the third edge onward.
- Down wrap and hold: from Q=0001 with En=1, Up=0 for 2 cycles → Q=0000, then 1111 with OVF=1. Then En=0 for 3 cycles → Q stays 1111.
- Load priority: at Q=0110 with En=1, Up=1, Load=1, D=0011 → Q=0011 and OVF cleared. With Load=0 on the next edge → Q=0100.
- Modulo mode: with TOGGLE_COUNTER_MOD_EN and MOD_VALUE=10:
  - Counting up from 1000 → 1001, then 0000 with OVF=1.
  - Load D=1100 → Q=1001.
  - Counting down from 0000 → Q=1001.
- Reset mid-count: with En=1, Up=1 at Q=0111, rst=1 for one cycle → Q=0000 on that edge. Counting resumes next cycle: Q=0001.
